data_mem_responder: RTL
=======================

# data_mem_responder

Memory-side responder for the core's MEM-stage data bus (the mem_read/mem_write/mem_addr/mem_wdata → mem_rdata/mem_ack interface driven by the atomic access path). Backs a word-organised on-chip data RAM and answers each request with a single-cycle ack after a programmable number of wait states. It also flags bad accesses so AMO, LR/SC and plain load/store sequences can be exercised cycle-accurately without the full Wishbone fabric.

## Interface
Parameters:
- DEPTH, 1024: RAM size in 32-bit words; power of two, 16..65536.
- LATENCY, 1: wait states between acceptance and ack; legal range 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read  in  2  00 none, 01 word, 10 halfword, 11 byte.
- mem_write  in  1  word write request.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data; valid in ack cycle, held until next ack.
- mem_ack  out  1  one-cycle completion pulse.
- mem_err  out  1  pulses with mem_ack when the access faulted.
- busy  out  1  high from acceptance through the ack cycle.

## Operation
- Request present = mem_write | (mem_read != 00), sampled only in IDLE.
- On acceptance, latch addr, wdata, size, rd/wr kind. Later input changes are ignored until ack.
- A request dropped mid-access still completes: ack pulses and any write commits.
- States:
  - IDLE: request → WAIT if LATENCY > 0, else RESP.
  - WAIT: down-counter loaded with LATENCY−1; reaching 0 → RESP.
  - RESP: mem_ack = 1 → IDLE.
- Back-to-back: a request still asserted in the first IDLE cycle after ack is a new access. The initiator must deassert in the ack cycle to avoid a repeat.
- Read: word index = addr[log2(DEPTH)+1:2].
  - Halfword selects addr[1]; byte selects addr[1:0]; both zero-extended.
- Write: word only; commits at the clock edge ending the RESP cycle.
- Read and write together: treated as write. mem_rdata returns the pre-write word (swap semantics).
- Fault (mem_err = 1 with ack) on any of:
  - word index ≥ DEPTH (addr[31:2] ≥ DEPTH);
  - word access with addr[1:0] != 0;
  - halfword access with addr[0] = 1.
- On fault: mem_rdata = 0, write suppressed, RAM unchanged.
- Reset values: state IDLE, mem_ack 0, mem_err 0, busy 0, mem_rdata 0. Reset mid-access discards the pending write; no ack is produced.
- RAM contents are not cleared by reset; initial contents are undefined.

## Timing
- Request in IDLE cycle 0 → mem_ack in cycle LATENCY+1.
  - LATENCY = 0 → ack in cycle 1; LATENCY = 3 → ack in cycle 4.
- Minimum throughput: one access per LATENCY+2 cycles; the mandatory IDLE cycle separates accesses.
- busy is high in cycles 1..LATENCY+1 and low in IDLE.
- mem_rdata updates only on the edge entering RESP; it is stable in the ack cycle and afterwards.
- Written data is visible to a read accepted in the IDLE cycle immediately after the write's ack.
- mem_ack and mem_err are registered outputs, with no combinational path from inputs.

## Structure
- Shared package mem_bus_pkg holds:
  - the size encodings MEM_NONE/MEM_WORD/MEM_HALF/MEM_BYTE, reused by the atomic access controller;
  - typedef resp_state_t {IDLE, WAIT, RESP}.
- One sub-module, sp_ram_array: single-port word RAM, parameter DEPTH, write enable, synchronous read, no reset. The responder owns the FSM, counter, alignment/range checks and lane extraction.

## Test plan
- LATENCY=0: write 0xDEADBEEF to 0x100, then word read 0x100 → acks in cycle 1 of each access; rdata 0xDEADBEEF, mem_err 0.
- LATENCY=3: halfword read 0x102 and byte read 0x103 of word 0x11223344 → ack in cycle 4; rdata 0x00001122, then 0x00000011.
- Fault cases, each returning ack, mem_err 1, rdata 0 and a later word read of 0x100 still returning 0xDEADBEEF:
  - word read 0x101;
  - halfword read 0x101;
  - DEPTH=1024 write to 0x1000.
- Read+write together at 0x200 (holding 5), wdata 9 → rdata 5 in ack cycle; next read of 0x200 returns 9.
- Request held high across ack → exactly one ack per LATENCY+2 cycles; addr change during WAIT is ignored.
- LATENCY=3 write of 0x77 to 0x300 (holding 0x11), rst asserted in cycle 2 → no ack, outputs at reset values, 0x300 still reads 0x11.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared MEM-stage bus definitions: access size encodings, responder states, lane extraction.
package mem_bus_pkg;

    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_WORD = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_BYTE = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    // Little-endian lane select, zero-extended; offsets assumed already checked for alignment.
    function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  off);
        logic [31:0] lane;
        lane = word;
        case (size)
            MEM_HALF: lane = {16'h0000, (off[1] ? word[31:16] : word[15:0])};
            MEM_BYTE: lane = {24'h000000, 8'(word >> {off, 3'b000})};
            default:  lane = word;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Single-port word RAM with synchronous read and no reset.
module sp_ram_array #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data bus responder: latches one request, waits LATENCY cycles, then acks from the RAM.
module data_mem_responder
    import mem_bus_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        busy
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [3:0]  CntLoad = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    resp_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  size_q;
    logic        wr_q;
    logic        ack_q, err_q;
    logic        rd_zero_q;
    logic [1:0]  rd_size_q, rd_off_q;

    logic        req;
    logic        accept;
    logic        enter_resp;
    logic [1:0]  in_size;
    logic [31:0] cur_addr;
    logic [1:0]  cur_size;
    logic        fault;
    logic        ram_we;
    logic [31:0] ram_rdata;

    assign req     = mem_write | (mem_read != MEM_NONE);
    assign accept  = (state_q == IDLE) & req;
    // Writes are word-only, including a read+write swap.
    assign in_size = mem_write ? MEM_WORD : mem_read;

    // In IDLE the live request is being decided on; afterwards only the latched copy matters.
    assign cur_addr = (state_q == IDLE) ? mem_addr : addr_q;
    assign cur_size = (state_q == IDLE) ? in_size  : size_q;

    assign fault = (|cur_addr[31:AW+2])
                 | ((cur_size == MEM_WORD) & (cur_addr[1:0] != 2'b00))
                 | ((cur_size == MEM_HALF) & cur_addr[0]);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CntLoad;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            size_q    <= MEM_NONE;
            wr_q      <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b1;
            rd_size_q <= MEM_WORD;
            rd_off_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= enter_resp;
            err_q   <= enter_resp & fault;
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                size_q  <= in_size;
                wr_q    <= mem_write;
            end
            // Read-path qualifiers move together with the RAM output register.
            if (enter_resp) begin
                rd_zero_q <= fault;
                rd_size_q <= cur_size;
                rd_off_q  <= cur_addr[1:0];
            end
        end
    end

    // Commit at the edge ending RESP, after the pre-write word was already read out.
    assign ram_we = (state_q == RESP) & wr_q & ~err_q;

    sp_ram_array #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (ram_we),
        .re_i   (enter_resp),
        .addr_i (cur_addr[AW+1:2]),
        .wdata_i(wdata_q),
        .rdata_o(ram_rdata)
    );

    assign mem_rdata = rd_zero_q ? 32'h0 : extract_lane(ram_rdata, rd_size_q, rd_off_q);
    assign mem_ack   = ack_q;
    assign mem_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule
